// File: rtl/led_port_pkg.sv
// rtl/led_port_pkg.sv - shared register map and status helpers for the LED output port
//
// Purpose : address constants, status bit positions and the status-word
//           builder shared by led_output_port and its bench.
// Contents: ADDR_DATA/ADDR_MASK/ADDR_PERIOD/ADDR_TOGGLE, STAT_PHASE/STAT_EN,
//           status_word(en, phase).
package led_port_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_MASK   = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_TOGGLE = 2'd3;

   localparam int STAT_PHASE = 0;
   localparam int STAT_EN    = 1;

   // Status word returned by a read of the toggle address.
   function automatic logic [31:0] status_word(input logic en, input logic phase);
      logic [31:0] s;
      s             = '0;
      s[STAT_EN]    = en;
      s[STAT_PHASE] = phase;
      return s;
   endfunction

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - prescaler plus half-period counter producing the blink phase
//
// Purpose : divides clk by TICK_DIV into ticks, counts `period` ticks per
//           half-cycle and toggles `phase` at each half-cycle boundary.
// Ports   : clk      - system clock
//           reset_n  - asynchronous active-low reset
//           period   - ticks per half-cycle (0 = disabled)
//           restart  - clears counters and sets phase=1 (period rewrite)
//           enable   - blink running (period != 0)
//           phase    - current blink phase, 1 = LEDs lit
module blink_timer #(
   parameter int PW       = 15,
   parameter int TICK_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [PW:0] period,
   input  logic        restart,
   input  logic        enable,
   output logic        phase
);

   localparam int             PSW      = $clog2(TICK_DIV);
   localparam logic [PSW-1:0] PRE_LAST = PSW'(TICK_DIV - 1);

   logic [PSW-1:0] prescaler;
   logic [PW:0]    half_cnt;   // PW+1 bits so the largest period never wraps
   logic           tick;

   assign tick = enable && (prescaler == PRE_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescaler <= '0;
         half_cnt  <= '0;
         phase     <= 1'b1;
      end else if (restart || !enable) begin
         // A period write beats a coincident tick; a disabled timer idles lit.
         prescaler <= '0;
         half_cnt  <= '0;
         phase     <= 1'b1;
      end else begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
         if (tick) begin
            if (half_cnt == period - 1'b1) begin
               half_cnt <= '0;
               phase    <= ~phase;
            end else begin
               half_cnt <= half_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/led_output_port.sv
// rtl/led_output_port.sv - Avalon-MM LED output port with toggle and blink
//
// Purpose : level register, write-1-to-toggle, per-bit blink mask and a
//           programmable blink generator driving the board LEDs.
// Ports   : clk, reset_n           - clock, asynchronous active-low reset
//           address, byteenable    - register select, write byte lanes
//           chipselect, read, write, writedata - bus request
//           readdata               - read data, valid one cycle after the strobe
//           LEDR                   - registered LED drive, active-high
module led_output_port
   import led_port_pkg::*;
#(
   parameter int DW       = 7,
   parameter int TICK_DIV = 50000,
   parameter int PW       = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic [3:0]  byteenable,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [DW:0] LEDR
);

   logic [DW:0]  data;
   logic [DW:0]  mask;
   logic [PW:0]  period;
   logic         phase;
   logic         wr_stb;
   logic         rd_stb;
   logic         restart;
   logic         enable;
   logic [31:0]  lane_bits;
   logic         unused_ok;

   assign wr_stb  = chipselect & write;
   assign rd_stb  = chipselect & read;
   assign restart = wr_stb && (address == ADDR_PERIOD);
   assign enable  = |period;

   // Byte enables expanded to one bit per data bit.
   assign lane_bits = {{8{byteenable[3]}}, {8{byteenable[2]}},
                       {8{byteenable[1]}}, {8{byteenable[0]}}};

   // Bits of the bus beyond the register widths are deliberately dropped.
   assign unused_ok = &{1'b0, writedata, lane_bits};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data   <= '0;
         mask   <= '0;
         period <= '0;
      end else if (wr_stb) begin
         case (address)
            ADDR_DATA:   data   <= (data & ~lane_bits[DW:0]) | (writedata[DW:0] & lane_bits[DW:0]);
            ADDR_MASK:   mask   <= (mask & ~lane_bits[DW:0]) | (writedata[DW:0] & lane_bits[DW:0]);
            ADDR_PERIOD: period <= (period & ~lane_bits[PW:0]) | (writedata[PW:0] & lane_bits[PW:0]);
            default:     data   <= data ^ writedata[DW:0];   // toggle ignores byteenable
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else if (rd_stb) begin
         case (address)
            ADDR_DATA:   readdata <= 32'(data);
            ADDR_MASK:   readdata <= 32'(mask);
            ADDR_PERIOD: readdata <= 32'(period);
            default:     readdata <= status_word(enable, phase);
         endcase
      end
   end

   blink_timer #(
      .PW       (PW),
      .TICK_DIV (TICK_DIV)
   ) u_blink_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .period  (period),
      .restart (restart),
      .enable  (enable),
      .phase   (phase)
   );

   // Masked bits go dark during the off half of the blink.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         LEDR <= '0;
      end else begin
         LEDR <= data & ~(mask & {(DW + 1){~phase}});
      end
   end

endmodule
